// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Radix-2 shift-add multiplier, restoring divider, one bit per cycle,
// WIDTH+1 busy cycles per arithmetic op. MTHI/MTLO write in one cycle.
// Optional divider: define MULDIV_DIV_EN to build DIV/DIVU; otherwise
// op 010/011 behave as no-ops.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               sa, sb;   // operand signs, zero for unsigned ops
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               req_ok, accept, mt_wr;
  logic               is_mul_op, is_div_op, signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_DIV_EN
  logic               is_div;   // op in flight is a divide
  logic               dz;       // divisor was zero
  logic [WIDTH:0]     div_shift, div_diff;
`endif

  // Request decode: only honoured in IDLE and never alongside a flush.
  assign req_ok    = (state == IDLE) & bus.start & ~bus.flush;
  assign is_mul_op = (bus.op[2:1] == 2'b00);
`ifdef MULDIV_DIV_EN
  assign is_div_op = (bus.op[2:1] == 2'b01);
`else
  assign is_div_op = 1'b0;
`endif
  assign accept    = req_ok & (is_mul_op | is_div_op);
  assign mt_wr     = req_ok & (bus.op[2:1] == 2'b10);
  assign signed_op = ~bus.op[0];
  assign a_abs     = (signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_abs     = (signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One iteration of the selected algorithm on the accumulator.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    step    = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      // Borrow means the trial subtract failed: keep the shifted remainder.
      if (div_diff[WIDTH]) step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Sign correction and special-case results presented at FIX.
  always_comb begin
    {res_hi, res_lo} = (sa ^ sb) ? -acc : acc;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // With a zero divisor the remainder path reproduces |a|, so the
      // remainder sign fix restores the original dividend.
      res_hi = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (dz)           res_lo = '1;
      else if (sa ^ sb) res_lo = -acc[WIDTH-1:0];
      else              res_lo = acc[WIDTH-1:0];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush aborts anything in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (bus.flush) state_nxt = IDLE;
               else if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch and per-cycle iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      dz     <= 1'b0;
`endif
    end else if (accept) begin
      acc  <= {{WIDTH{1'b0}}, is_div_op ? a_abs : b_abs};
      opnd <= is_div_op ? b_abs : a_abs;
      cnt  <= CW'(WIDTH);
      sa   <= signed_op & bus.a[WIDTH-1];
      sb   <= signed_op & bus.b[WIDTH-1];
`ifdef MULDIV_DIV_EN
      is_div <= is_div_op;
      dz     <= is_div_op & (bus.b == '0);
`endif
    end else if (state == RUN) begin
      acc <= step;
      cnt <= cnt - CW'(1);
    end
  end

  // Architectural HI/LO: written only by a FIX commit or MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == FIX && !bus.flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end else if (mt_wr) begin
        if (bus.op[0]) lo_q <= bus.a;
        else           hi_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter at WIDTH=32 against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_iter;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus ();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    bus.start = 1'b0; bus.op = 3'b111; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
  endtask

  // Reference: plain integer arithmetic on the architectural HI/LO.
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint    x, y, q, r;
    logic [63:0] p;
    x = longint'($signed(a));
    y = longint'($signed(b));
    case (op)
      3'b000: begin p = 64'(x * y); {m_hi, m_lo} = p; end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'b010, 3'b011: if (DIV_EN) begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else if (op == 3'b010) begin
          q = x / y; r = x % y;
          p = 64'(q); m_lo = p[31:0];
          p = 64'(r); m_hi = p[31:0];
        end else begin m_lo = a / b; m_hi = a % b; end
      end
      3'b100: m_hi = a;
      3'b101: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one arithmetic op and wait (bounded) for busy to drop.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int cyc, output logic done_seen);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin tick; cyc++; end
    done_seen = bus.done;
  endtask

  task automatic test_reset;
    reset = 1'b0; idle_inputs;
    tick; tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    checks++; if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_arith(input string name, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc; logic dn;
    do_op(op, a, b, cyc, dn);
    model_op(op, a, b);
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, LAT); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL %s_done got=%b want=1", name, dn); end
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL %s_hi got=%h want=%h", name, bus.hi, m_hi); end
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL %s_lo got=%h want=%h", name, bus.lo, m_lo); end
    tick;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b want=0", name, bus.done); end
  endtask

  task automatic test_directed;
    test_arith("mult_neg", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_neg_const got=%h want=fffffffffffffffa", {bus.hi, bus.lo}); end
    test_arith("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max_const got=%h want=fffffffe00000001", {bus.hi, bus.lo}); end
    if (DIV_EN) begin
      test_arith("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2);
      checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg_const got=%h want=fffffffffffffffd", {bus.hi, bus.lo}); end
      test_arith("divu", 3'b011, 32'd100, 32'd7);
      checks++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_const got=%h want=%h", {bus.hi, bus.lo}, {32'd2, 32'd14}); end
      test_arith("divu_zero", 3'b011, 32'h1234, 32'h0);
      checks++; if ({bus.hi, bus.lo} !== {32'h1234, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_zero_const got=%h", {bus.hi, bus.lo}); end
      test_arith("div_zero_neg", 3'b010, 32'hFFFF_FF00, 32'h0);
      test_arith("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      checks++; if ({bus.hi, bus.lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_ovf_const got=%h", {bus.hi, bus.lo}); end
    end
  endtask

  task automatic test_mt;
    logic [W-1:0] v;
    v = $urandom;
    bus.start = 1'b1; bus.op = 3'b101; bus.a = v; tick; idle_inputs;
    model_op(3'b101, v, '0);
    checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL mtlo got=%h want=%h", bus.lo, m_lo); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_hs got=%b%b want=00", bus.busy, bus.done); end
    v = $urandom;
    bus.start = 1'b1; bus.op = 3'b100; bus.a = v; tick; idle_inputs;
    model_op(3'b100, v, '0);
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL mthi got=%h want=%h", bus.hi, m_hi); end
    // no-op encoding leaves everything alone
    bus.start = 1'b1; bus.op = 3'b110; bus.a = ~v; tick; idle_inputs;
    checks++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL noop got=%b %h %h want=0 %h %h", bus.busy, bus.hi, bus.lo, m_hi, m_lo); end
  endtask

  task automatic test_flush_idle;
    bus.start = 1'b1; bus.op = 3'b100; bus.a = ~m_hi; bus.flush = 1'b1; tick;
    checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL flush_idle_mthi got=%h want=%h", bus.hi, m_hi); end
    bus.op = 3'b001; bus.a = 32'd5; bus.b = 32'd6; tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_mult got=%b want=0", bus.busy); end
    idle_inputs; tick;
  endtask

  task automatic test_abort;
    logic seen;
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hA5A5_A5A5; tick; idle_inputs;
    model_op(3'b100, 32'hA5A5_A5A5, '0);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4; tick; bus.start = 1'b0;
    repeat (9) tick;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
    bus.flush = 1'b1; tick; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_hs got=%b%b want=00", bus.busy, bus.done); end
    seen = 1'b0;
    repeat (40) begin tick; if (bus.done || bus.busy) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_late_activity got=%b want=0", seen); end
    checks++; if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== m_lo) begin errors++; $display("FAIL abort_hilo got=%h %h want=a5a5a5a5 %h", bus.hi, bus.lo, m_lo); end
  endtask

  task automatic test_start_while_busy;
    logic [W-1:0] a, b; int cyc;
    a = $urandom; b = $urandom;
    bus.start = 1'b1; bus.op = 3'b001; bus.a = a; bus.b = b; tick;
    repeat (4) tick;
    bus.op = 3'b100; bus.a = ~a; tick;
    bus.op = 3'b000; bus.b = 32'd1; tick;
    bus.op = 3'b101; tick;
    bus.start = 1'b0;
    cyc = 7;
    while (bus.busy && cyc < 200) begin tick; cyc++; end
    model_op(3'b001, a, b);
    checks++; if (cyc !== LAT || bus.done !== 1'b1) begin errors++; $display("FAIL busy_ignore_lat got=%0d/%b want=%0d/1", cyc, bus.done, LAT); end
    checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL busy_ignore_res got=%h %h want=%h %h", bus.hi, bus.lo, m_hi, m_lo); end
    tick;
  endtask

  task automatic test_back_to_back;
    int cyc; logic dn;
    logic [W-1:0] a, b;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFB, cyc, dn);
    model_op(3'b000, 32'd7, 32'hFFFF_FFFB);
    checks++; if (dn !== 1'b1 || bus.lo !== m_lo) begin errors++; $display("FAIL b2b_first got=%b %h want=1 %h", dn, bus.lo, m_lo); end
    a = $urandom; b = $urandom;
    bus.start = 1'b1; bus.op = 3'b001; bus.a = a; bus.b = b; tick; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b want=1", bus.busy); end
    cyc = 0;
    while (bus.busy && cyc < 200) begin tick; cyc++; end
    model_op(3'b001, a, b);
    checks++; if (cyc !== LAT || bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL b2b_second got=%0d %h %h want=%0d %h %h", cyc, bus.hi, bus.lo, LAT, m_hi, m_lo); end
    tick;
  endtask

  task automatic test_no_div;
    logic seen;
    if (!DIV_EN) begin
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7; tick; bus.start = 1'b0;
      seen = bus.busy;
      repeat (5) begin tick; if (bus.busy || bus.done) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL nodiv_busy got=%b want=0", seen); end
      checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL nodiv_hilo got=%h %h want=%h %h", bus.hi, bus.lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b; logic [2:0] op;
    for (int i = 0; i < 30; i++) begin
      op = DIV_EN ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      test_arith("rand", op, a, b);
    end
  endtask

  task automatic test_reset_mid;
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4; tick; bus.start = 1'b0;
    repeat (5) tick;
    #2 reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_hs got=%b%b want=00", bus.busy, bus.done); end
    checks++; if (bus.hi !== '0 || bus.lo !== '0) begin errors++; $display("FAIL rst_mid_hilo got=%h %h want=0 0", bus.hi, bus.lo); end
    tick; reset = 1'b1;
    repeat (3) tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after got=%b want=0", bus.busy); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mt;
    test_flush_idle;
    test_abort;
    test_start_while_busy;
    test_back_to_back;
    test_no_div;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit holding the architectural HI/LO pair, sitting beside the ALU in the EX stage. It replaces fixed-latency behavioural arithmetic with a radix-2 shift-add multiplier and a restoring divider whose latency scales with operand width. It adds a busy/done handshake, a pipeline flush abort, and defined divide-by-zero results.

## Interface
- WIDTH, 32: operand width and HI/LO width. Must be even and at least 4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; qualifies op, a and b.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- flush  in  1  abort any in-flight operation.
- busy  out  1  arithmetic in progress; the pipeline must stall MF*/MT*/MUL*/DIV* while it is high.
- done  out  1  one-cycle pulse on the edge that commits HI/LO.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**
  - start & op∈{MULT,MULTU,DIV,DIVU} & !flush: latch operands and go to RUN.
  - Signed ops latch |a| and |b|, plus the sign flags sa and sb.
  - The iteration counter is loaded with WIDTH.
- **RUN**
  - One iteration per cycle; the counter decrements.
  - Multiply: 2·WIDTH-bit product accumulator, shift-add on multiplier LSB.
  - Divide: restoring; shift remainder:quotient left, trial-subtract the divisor, set quotient bit if no borrow.
  - When the counter reaches 0, go to FIX.
- **FIX**
  - Sign correction.
  - MULT: negate the product if sa^sb.
  - DIV: negate the quotient if sa^sb; negate the remainder if sa.
  - Commit {hi,lo} = product, or hi = remainder and lo = quotient.
  - Pulse done and return to IDLE.
- **Divide by zero** (b==0, signed or unsigned): hi = a (original dividend), lo = all ones. The full latency still applies.
- **Signed overflow** (DIV with a = most negative, b = −1): lo = most negative, hi = 0, with no trap.
- **MTHI/MTLO**
  - start & op=MTHI in IDLE: hi <= a on that edge. MTLO does the same for lo.
  - No busy, no done.
- start while busy is ignored, for every op; HI/LO are unaffected.
- **flush**
  - In RUN or FIX: return to IDLE on the next edge, HI/LO keep their old values, no done.
  - In IDLE: suppresses a same-cycle start, including MTHI/MTLO.
- hi and lo change only on a FIX commit or an MTHI/MTLO write.

## Timing
- **Reset** (asynchronous, reset=0):
  - State = IDLE; busy=0, done=0, hi=0, lo=0; counter and accumulators cleared.
  - Reset mid-operation discards the result.
- **Latency**
  - Accept edge T, where start is sampled in IDLE.
  - busy=1 from T through T+WIDTH+1.
  - HI/LO are updated and done=1 after edge T+WIDTH+1.
  - busy=0 in that same cycle.
  - Total: WIDTH+1 cycles of busy (33 at WIDTH=32).
- **Back-to-back:** a new start is accepted in the cycle where done=1, because busy is already 0.
- **MTHI/MTLO:** new value visible on hi/lo the cycle after the accept edge.
- **Registered outputs:** busy, done, hi and lo are all registered; there is no combinational path from inputs to outputs.

## Configuration
- **MULDIV_DIV_EN defined:** the divider datapath and DIV/DIVU are as above.
- **MULDIV_DIV_EN undefined:**
  - No divider logic is built.
  - op 010/011 is treated as a no-op: no busy, no done, HI/LO unchanged.
  - The multiply and MT* behaviour is identical to the full build.

## Test plan
All scenarios at WIDTH=32.
- **Signed multiply:** MULT a=0xFFFFFFFE (−2), b=0x00000003 -> busy for 33 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **Unsigned multiply:** MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- **Signed divide:** DIV a=−7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- **Unsigned divide:** DIVU a=100, b=7 -> lo=14, hi=2.
- **Divide edge cases:**
  - DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Abort and reset:**
  - MTHI a=0xA5A5A5A5, then MULT 3×4, flush asserted at cycle 10 of busy -> busy=0 next cycle, no done, hi=0xA5A5A5A5.
  - Repeat the MULT and assert reset mid-RUN -> all outputs 0 immediately.
  - With MULDIV_DIV_EN undefined, DIV start -> busy stays 0.
